uart_boot_loader: RTL and testbench
===================================

# uart_boot_loader

- Sits directly downstream of the UART byte receiver and consumes its one-cycle `rx_valid`/`rx_data` byte stream.
- Parses a framed program image: a length field, the payload words, then a checksum byte.
- Assembles little-endian 32-bit words and writes each one to instruction memory through a single-cycle write port.
- Holds the CPU in reset until a load completes with a matching checksum.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first payload word.
- `MAX_WORDS`, default 4096: largest accepted length field, in words.
- `TIMEOUT_CYCLES`, default 100_000: idle clocks allowed between bytes inside a frame (2 ms at 50 MHz).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `rx_data`  in  8  received byte; valid only while `rx_valid`=1.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  32  byte address of the write; always word aligned.
- `mem_wdata`  out  32  assembled word.
- `cpu_hold`  out  1  1 keeps the core in reset.
- `load_done`  out  1  level; 1 after a successful load.
- `load_error`  out  1  sticky; 1 after a length, timeout or checksum error.

## Operation
- Frame format:
  - 4 length bytes, little-endian word count N.
  - 4·N payload bytes, little-endian words.
  - 1 checksum byte = sum of all payload bytes mod 256. Length bytes are not included in the sum.
- States and transitions:
  - LEN: collects the 4 length bytes. After the 4th byte:
    - N==0 or N>MAX_WORDS → error.
    - Otherwise latch N, clear word index, byte count and checksum, go to DATA.
  - DATA: each byte is shifted into bits [8·k+7:8·k], k = byte count 0..3.
    - On the 4th byte, issue a write at BASE_ADDR + 4·word_index and increment word_index.
    - When word_index reaches N, go to CSUM.
    - Each payload byte is added to the 8-bit running sum, which wraps.
  - CSUM: the next byte is compared with the running sum.
    - Equal → DONE.
    - Not equal → error.
  - DONE: `cpu_hold`=0, `load_done`=1. All further bytes are ignored until `reset`.
- Error action:
  - Set `load_error`.
  - Clear byte count, word index and checksum; return to LEN.
  - `cpu_hold` stays 1.
  - Memory already written is not rolled back; a retransmitted frame overwrites it.
- `load_error` clears only on entry to DONE or on `reset`.
- Timeout:
  - The idle counter clears on every `rx_valid`.
  - In LEN with ≥1 length byte, or in DATA or CSUM, the counter reaching TIMEOUT_CYCLES triggers the error action.
  - There is no timeout in LEN with 0 bytes, or in DONE.
- `rx_valid` asserted in the same cycle the timeout would fire: the byte is taken and the timeout does not fire.
- `rx_data` is ignored whenever `rx_valid`=0.

## Timing
- Reset values:
  - State LEN, all counters 0.
  - `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `load_error`=0.
- `reset` mid-frame aborts the load, returns all of the above to reset values and re-asserts `cpu_hold` at the next edge.
- All outputs are registered.
- Write timing:
  - `mem_we` is high for exactly the one cycle after the `rx_valid` that carries a word's 4th byte.
  - `mem_addr` and `mem_wdata` are valid in that same cycle and hold until the next write.
- Completion timing:
  - `load_done`→1 and `cpu_hold`→0 in the cycle after the `rx_valid` carrying a correct checksum.
  - On any error, `load_error`→1 in the cycle after the triggering byte, or after the cycle the timeout count is reached.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss.
- Minimum latency from a word's last byte to its write is 1 clock.

## Test plan
- Good load:
  - Stimulus: bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | B6.
  - Required: write 0x00000013 @0x0, then 0x00100093 @0x4; `load_done`=1 and `cpu_hold`=0 one cycle after the B6 byte; `load_error`=0.
- Checksum error then retry:
  - Stimulus: the same frame with checksum 0xB5.
  - Required: `load_error`=1, `cpu_hold`=1.
  - Stimulus: resend the correct frame.
  - Required: `load_done`=1, `load_error`=0, memory contents correct.
- Bad length:
  - Stimulus: length 0x00000000, then length MAX_WORDS+1.
  - Required: `load_error`=1 after each 4th length byte; no `mem_we` pulses.
- Inter-byte timeout:
  - Stimulus: stop after 6 bytes of a valid frame and wait TIMEOUT_CYCLES.
  - Required: `load_error`=1, state LEN; a following full valid frame loads correctly.
  - Also check: a byte arriving on exactly the timeout cycle is accepted and no error is flagged.
- Reset mid-load and ignored bytes:
  - Stimulus: assert `reset` during DATA.
  - Required: all outputs at reset values next cycle; a fresh frame loads correctly.
  - Stimulus: send bytes while in DONE.
  - Required: no `mem_we`, and `load_done` stays 1.
- Back-to-back bytes: `rx_valid` held high for 13 consecutive cycles with the good-load frame → identical writes and completion to the good-load case.

Source files
------------

// File: rtl/uart_boot_loader_if.sv
// Byte stream in from the UART receiver, instruction-memory write port and
// CPU control out. dbg_state mirrors the loader FSM: 0=LEN 1=DATA 2=CSUM 3=DONE.
interface uart_boot_loader_if;
  // rx_valid is a one-cycle strobe with no ready: every byte presented with
  // rx_valid=1 is consumed on that edge; rx_data is ignored while rx_valid=0.
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [1:0]  dbg_state;

  modport master (
    output rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, dbg_state
  );

  modport slave (
    input  rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, dbg_state
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Parses a length/payload/checksum frame from the UART byte stream, writes the
// payload words to instruction memory and releases the CPU on a good checksum.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input logic              clk,
  input logic              reset,
  uart_boot_loader_if.slave bus
);

  typedef enum logic [1:0] {ST_LEN, ST_DATA, ST_CSUM, ST_DONE} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic [31:0] len_q;
  logic [31:0] idx_q;
  logic [7:0]  sum_q;
  logic [31:0] idle_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        hold_q;
  logic        done_q;
  logic        err_q;

  logic [31:0] asm_d;
  logic        timed;
  logic        timeout;
  logic        bad_len;
  logic        bad_sum;
  logic        fail_d;

  // Length and payload share one shift register; the 4th byte completes a word.
  always_comb begin
    asm_d   = {bus.rx_data, shift_q};
    timed   = ((state_q == ST_LEN) && (cnt_q != 2'd0)) ||
              (state_q == ST_DATA) || (state_q == ST_CSUM);
    timeout = !bus.rx_valid && timed && (idle_q == 32'(TIMEOUT_CYCLES - 1));
    bad_len = (state_q == ST_LEN) && (cnt_q == 2'd3) &&
              ((asm_d == 32'd0) || (asm_d > 32'(MAX_WORDS)));
    bad_sum = (state_q == ST_CSUM) && (bus.rx_data != sum_q);
    fail_d  = timeout || (bus.rx_valid && (bad_len || bad_sum));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LEN;
      cnt_q   <= 2'd0;
      shift_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (bus.rx_valid || !timed || fail_d) idle_q <= '0;
      else                                  idle_q <= idle_q + 32'd1;

      // Errors restart framing but leave memory and cpu_hold untouched.
      if (fail_d) begin
        err_q   <= 1'b1;
        state_q <= ST_LEN;
        cnt_q   <= 2'd0;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (bus.rx_valid) begin
        case (state_q)
          ST_LEN: begin
            shift_q <= {bus.rx_data, shift_q[23:8]};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              len_q   <= asm_d;
              idx_q   <= '0;
              sum_q   <= '0;
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            shift_q <= {bus.rx_data, shift_q[23:8]};
            cnt_q   <= cnt_q + 2'd1;
            sum_q   <= sum_q + bus.rx_data;
            if (cnt_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= BASE_ADDR + {idx_q[29:0], 2'b00};
              wdata_q <= asm_d;
              idx_q   <= idx_q + 32'd1;
              if (idx_q + 32'd1 == len_q) state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
          end
          ST_DONE: ;
        endcase
      end
    end
  end

  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: frames are built from word images,
// expected writes and outcomes come from the frame rules, not the FSM.
module tb_uart_boot_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 8;
  localparam int TO   = 40;
  localparam logic [1:0] ST_LEN = 2'd0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_boot_loader_if bus();

  uart_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int cmp_cnt = 0;
  int fail_cnt = 0;
  logic [7:0]  frame_q[$];
  logic [31:0] img_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] dut_mem[logic [31:0]];

  // Write monitor: every cycle with mem_we high is one observed write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      obs_q.push_back({bus.mem_addr, bus.mem_wdata});
      dut_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Reference model: frame bytes, expected write list and memory image.
  task automatic make_frame(input int n, input bit keep_img, input bit corrupt);
    int sum;
    logic [7:0] b8;
    if (!keep_img) begin
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
    end
    frame_q.delete();
    exp_q.delete();
    sum = 0;
    for (int b = 0; b < 4; b++) frame_q.push_back(8'(n >> (8 * b)));
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        b8 = img_q[i][8*b +: 8];
        frame_q.push_back(b8);
        sum += int'(b8);
      end
      exp_q.push_back({BASE + 32'(4 * i), img_q[i]});
      mem_model[BASE + 32'(4 * i)] = img_q[i];
    end
    frame_q.push_back(8'(sum) ^ (corrupt ? 8'h01 : 8'h00));
  endtask

  task automatic send_frame(input int first, input int last, input int gap_max);
    for (int i = first; i < last; i++) begin
      send_byte(frame_q[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++; if (bus.mem_we !== 1'b0) begin fail_cnt++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    cmp_cnt++; if (bus.mem_addr !== BASE) begin fail_cnt++; $display("FAIL rst_addr: got %h want %h", bus.mem_addr, BASE); end
    cmp_cnt++; if (bus.mem_wdata !== 32'd0) begin fail_cnt++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
    cmp_cnt++; if (bus.cpu_hold !== 1'b1) begin fail_cnt++; $display("FAIL rst_hold: got %b want 1", bus.cpu_hold); end
    cmp_cnt++; if (bus.load_done !== 1'b0) begin fail_cnt++; $display("FAIL rst_done: got %b want 0", bus.load_done); end
    cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL rst_err: got %b want 0", bus.load_error); end
    cmp_cnt++; if (bus.dbg_state !== ST_LEN) begin fail_cnt++; $display("FAIL rst_state: got %0d want %0d", bus.dbg_state, ST_LEN); end
  endtask

  task automatic test_good_load(input string name, input int gap_max);
    do_reset();
    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'h0010_0093);
    make_frame(2, 1'b1, 1'b0);
    send_frame(0, 12, gap_max);
    cmp_cnt++; if (bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b1) begin fail_cnt++; $display("FAIL %s_early: done=%b hold=%b want 0/1", name, bus.load_done, bus.cpu_hold); end
    send_byte(frame_q[12]);
    cmp_cnt++; if (bus.load_done !== 1'b1) begin fail_cnt++; $display("FAIL %s_done: got %b want 1", name, bus.load_done); end
    cmp_cnt++; if (bus.cpu_hold !== 1'b0) begin fail_cnt++; $display("FAIL %s_hold: got %b want 0", name, bus.cpu_hold); end
    cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL %s_err: got %b want 0", name, bus.load_error); end
    idle(2);
    cmp_cnt++; if (obs_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL %s_nwrites: got %0d want %0d", name, obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      cmp_cnt++; if (obs_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL %s_write%0d: got %h want %h", name, i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_csum_retry();
    do_reset();
    make_frame(2, 1'b1, 1'b1);
    send_frame(0, frame_q.size(), 2);
    cmp_cnt++; if (bus.load_error !== 1'b1) begin fail_cnt++; $display("FAIL csum_err: got %b want 1", bus.load_error); end
    cmp_cnt++; if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin fail_cnt++; $display("FAIL csum_hold: hold=%b done=%b want 1/0", bus.cpu_hold, bus.load_done); end
    cmp_cnt++; if (bus.dbg_state !== ST_LEN) begin fail_cnt++; $display("FAIL csum_state: got %0d want %0d", bus.dbg_state, ST_LEN); end
    make_frame(2, 1'b1, 1'b0);
    obs_q.delete();
    send_frame(0, frame_q.size(), 2);
    cmp_cnt++; if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL retry_done: done=%b err=%b want 1/0", bus.load_done, bus.load_error); end
    idle(2);
    cmp_cnt++; if (obs_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL retry_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < 2; i++) begin
      cmp_cnt++;
      if (!dut_mem.exists(BASE + 32'(4 * i)) || dut_mem[BASE + 32'(4 * i)] !== mem_model[BASE + 32'(4 * i)]) begin
        fail_cnt++; $display("FAIL retry_mem%0d: want %h", i, mem_model[BASE + 32'(4 * i)]);
      end
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] lens [2];
    lens[0] = 32'd0;
    lens[1] = 32'(MAXW + 1);
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int b = 0; b < 3; b++) send_byte(lens[k][8*b +: 8]);
      cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL badlen%0d_early: got %b want 0", k, bus.load_error); end
      send_byte(lens[k][31:24]);
      cmp_cnt++; if (bus.load_error !== 1'b1) begin fail_cnt++; $display("FAIL badlen%0d_err: got %b want 1", k, bus.load_error); end
      cmp_cnt++; if (bus.dbg_state !== ST_LEN) begin fail_cnt++; $display("FAIL badlen%0d_state: got %0d want %0d", k, bus.dbg_state, ST_LEN); end
      idle(3);
      cmp_cnt++; if (obs_q.size() != 0) begin fail_cnt++; $display("FAIL badlen%0d_writes: got %0d want 0", k, obs_q.size()); end
    end
    do_reset();
    make_frame(MAXW, 1'b0, 1'b0);
    send_frame(0, frame_q.size(), 1);
    cmp_cnt++; if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL maxlen_done: done=%b err=%b want 1/0", bus.load_done, bus.load_error); end
    idle(2);
    cmp_cnt++; if (obs_q.size() != MAXW) begin fail_cnt++; $display("FAIL maxlen_nwrites: got %0d want %0d", obs_q.size(), MAXW); end
  endtask

  task automatic test_timeout();
    do_reset();
    idle(3 * TO);
    cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL to_idle_len: got %b want 0", bus.load_error); end
    send_byte(8'h01);
    idle(TO - 1);
    cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL to_len_early: got %b want 0", bus.load_error); end
    idle(1);
    cmp_cnt++; if (bus.load_error !== 1'b1) begin fail_cnt++; $display("FAIL to_len_fire: got %b want 1", bus.load_error); end

    do_reset();
    make_frame(2, 1'b0, 1'b0);
    send_frame(0, 6, 0);
    idle(TO - 1);
    cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL to_data_early: got %b want 0", bus.load_error); end
    idle(1);
    cmp_cnt++; if (bus.load_error !== 1'b1) begin fail_cnt++; $display("FAIL to_data_fire: got %b want 1", bus.load_error); end
    cmp_cnt++; if (bus.dbg_state !== ST_LEN) begin fail_cnt++; $display("FAIL to_state: got %0d want %0d", bus.dbg_state, ST_LEN); end
    cmp_cnt++; if (obs_q.size() != 0) begin fail_cnt++; $display("FAIL to_writes: got %0d want 0", obs_q.size()); end
    make_frame(3, 1'b0, 1'b0);
    send_frame(0, frame_q.size(), 3);
    cmp_cnt++; if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL to_reload: done=%b err=%b want 1/0", bus.load_done, bus.load_error); end
    idle(2);
    cmp_cnt++; if (obs_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL to_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      cmp_cnt++; if (obs_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL to_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end

    // Every byte lands on the last cycle before the timeout would fire.
    do_reset();
    make_frame(2, 1'b0, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i]);
      if (i < frame_q.size() - 1) idle(TO - 1);
    end
    cmp_cnt++; if (bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL to_edge_err: got %b want 0", bus.load_error); end
    cmp_cnt++; if (bus.load_done !== 1'b1) begin fail_cnt++; $display("FAIL to_edge_done: got %b want 1", bus.load_done); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    make_frame(3, 1'b0, 1'b0);
    send_frame(0, 10, 0);
    idle(1);
    cmp_cnt++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin fail_cnt++; $display("FAIL mid_first_write: n=%0d want 1 of %h", obs_q.size(), exp_q[0]); end
    reset = 1'b1;
    @(negedge clk);
    cmp_cnt++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== BASE || bus.mem_wdata !== 32'd0) begin fail_cnt++; $display("FAIL mid_rst_mem: we=%b addr=%h wdata=%h want 0/%h/0", bus.mem_we, bus.mem_addr, bus.mem_wdata, BASE); end
    cmp_cnt++; if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL mid_rst_ctl: hold=%b done=%b err=%b want 1/0/0", bus.cpu_hold, bus.load_done, bus.load_error); end
    cmp_cnt++; if (bus.dbg_state !== ST_LEN) begin fail_cnt++; $display("FAIL mid_rst_state: got %0d want %0d", bus.dbg_state, ST_LEN); end
    reset = 1'b0;
    obs_q.delete();
    make_frame(2, 1'b0, 1'b0);
    send_frame(0, frame_q.size(), 2);
    cmp_cnt++; if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin fail_cnt++; $display("FAIL mid_reload: done=%b hold=%b want 1/0", bus.load_done, bus.cpu_hold); end
    idle(2);
    cmp_cnt++; if (obs_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL mid_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      cmp_cnt++; if (obs_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL mid_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom));
      idle($urandom_range(0, 1));
    end
    idle(2);
    cmp_cnt++; if (obs_q.size() != 0) begin fail_cnt++; $display("FAIL done_ignore_writes: got %0d want 0", obs_q.size()); end
    cmp_cnt++; if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.load_error !== 1'b0) begin fail_cnt++; $display("FAIL done_ignore_ctl: done=%b hold=%b err=%b want 1/0/0", bus.load_done, bus.cpu_hold, bus.load_error); end
  endtask

  task automatic test_random();
    int n;
    bit corrupt;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      n = $urandom_range(1, MAXW);
      corrupt = 1'($urandom_range(0, 1));
      make_frame(n, 1'b0, corrupt);
      send_frame(0, frame_q.size(), 3);
      cmp_cnt++; if (bus.load_done !== !corrupt || bus.load_error !== corrupt || bus.cpu_hold !== corrupt) begin
        fail_cnt++; $display("FAIL rand%0d_ctl: done=%b err=%b hold=%b corrupt=%b", t, bus.load_done, bus.load_error, bus.cpu_hold, corrupt);
      end
      idle(2);
      cmp_cnt++; if (obs_q.size() != exp_q.size()) begin fail_cnt++; $display("FAIL rand%0d_nwrites: got %0d want %0d", t, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        cmp_cnt++; if (obs_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL rand%0d_write%0d: got %h want %h", t, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_good_load("good", 2);
    test_csum_retry();
    test_bad_length();
    test_timeout();
    test_reset_mid_load();
    test_good_load("b2b", 0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
